// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings, index width,
// default start timeout and the round-robin pointer advance helper.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT = 16;

  // Requester index width; covers NREQ up to 8.
  localparam int IDX_W = 3;

  // Pointer moves to the slot just after the winner, wrapping at nreq.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx,
                                                input int nreq);
    if (int'(idx) == nreq - 1) return '0;
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or after
// ptr, wrapping from NREQ-1 back to 0.
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] masked;

  // Duplicate req and mask off the lower copy below ptr; the upper copy holds the wrapped candidates.
  always_comb begin
    dbl    = {req, req};
    masked = '0;
    for (int j = 0; j < 2*NREQ; j++) begin
      masked[j] = dbl[j] & (j >= int'(ptr));
    end
  end

  // Lowest set bit of the masked vector wins; fold the upper copy back onto 0..NREQ-1.
  always_comb begin
    idx = '0;
    for (int j = 2*NREQ-1; j >= 0; j--) begin
      if (masked[j]) begin
        idx = (j >= NREQ) ? IDX_W'(j - NREQ) : IDX_W'(j);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte sources.
// Sequences the core's tx_wr/tx_busy handshake and flags a missing busy rise.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data,
  output logic [NREQ-1:0]   ack,
  output logic              tx_wr,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [2:0]        grant_id,
  output logic              err_timeout
);

  localparam int TIMER_W = $clog2(TIMEOUT);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic               tx_wr_q, tx_wr_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic               err_c;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;

  uart_tx_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Next-state, grant latch, pointer and timer logic; tx_wr/ack are registered so they line up with ISSUE.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    timer_d    = timer_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    tx_wr_d    = 1'b0;
    ack_d      = '0;
    err_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any && !tx_busy) begin
          state_d    = ST_ISSUE;
          grant_id_d = pick_idx;
          ptr_d      = next_ptr(pick_idx, NREQ);
          timer_d    = '0;
          tx_wr_d    = 1'b1;
          for (int i = 0; i < NREQ; i++) begin
            ack_d[i] = (pick_idx == IDX_W'(i));
            if (pick_idx == IDX_W'(i)) tx_data_d = data[8*i +: 8];
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
        timer_d = '0;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          // Pulse in the last waiting cycle so it lands TIMEOUT cycles after tx_wr.
          err_c   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset also abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      timer_q    <= '0;
      tx_data_q  <= '0;
      grant_id_q <= '0;
      tx_wr_q    <= 1'b0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      timer_q    <= timer_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
      tx_wr_q    <= tx_wr_d;
      ack_q      <= ack_d;
    end
  end

  assign ack         = ack_q;
  assign tx_wr       = tx_wr_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign err_timeout = err_c & rst;

endmodule
